// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2,
    RUN    = 2'd3
  } imem_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot byte stream plus instruction-memory write port, seen from both ends.
interface imem_boot_loader_if
  import imem_pkg::*;
#(
  parameter int unsigned AW = IMEM_AW
) ();

  logic              s_valid;
  logic [BYTE_W-1:0] s_data;
  logic              s_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  // Loader side: consumes the stream, drives the memory write port.
  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_waddr, mem_wdata
  );

  // Environment side: boot source and memory model.
  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Assembles accepted stream bytes into little-endian 32-bit words and
// pulses word_valid for one cycle once a word is complete.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              ready,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              word_done_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0] byte_cnt;
  logic       accept;

  assign accept      = ready & s_valid;
  assign word_done_c = accept && (byte_cnt == 2'd3);

  // Byte k of a word lands in bits [8k+7:8k]; word stays stable during the write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_done_c;
      if (clear) begin
        byte_cnt <= 2'd0;
      end else if (accept) begin
        word[{byte_cnt, 3'b000} +: BYTE_W] <= s_data;
        byte_cnt                           <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time loader: streams bytes into instruction memory, holds the core
// until the image is written, then opens and range-checks the fetch path.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = IMEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW:0]       load_len,
  imem_boot_loader_if.slave bus,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       imem_rd_addr,
  output logic              core_hold,
  output logic              fetch_fault,
  output logic [AW:0]       words_loaded,
  output logic [31:0]       checksum,
  output logic              load_err
);

  localparam logic [AW:0] DEPTH_LEN  = (AW+1)'(DEPTH);
  localparam logic [31:0] DEPTH_ADDR = 32'(DEPTH);

  imem_state_t       state_q;
  logic              ready_q;
  logic [AW:0]       len_q;
  logic [AW:0]       word_cnt;
  logic              word_done_c;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic              start_ok;
  logic              load_go;
  logic              last_word;

  // start is only honoured while the core is parked or running.
  assign start_ok  = start && ((state_q == IDLE) || (state_q == RUN));
  assign load_go   = start_ok && (load_len != '0) && (load_len <= DEPTH_LEN);
  assign last_word = word_done_c && ((word_cnt + (AW+1)'(1)) == len_q);

  imem_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (load_go),
    .ready       (ready_q),
    .s_valid     (bus.s_valid),
    .s_data      (bus.s_data),
    .word_done_c (word_done_c),
    .word_valid  (word_valid),
    .word        (word)
  );

  // Write port is driven straight from the packer's registered word and the word counter.
  assign bus.s_ready   = ready_q;
  assign bus.mem_we    = word_valid;
  assign bus.mem_waddr = word_cnt[AW-1:0];
  assign bus.mem_wdata = word;
  assign words_loaded  = word_cnt;

  assign imem_rd_addr = (state_q == RUN) ? fetch_addr : '0;
  assign fetch_fault  = (state_q == RUN) && (fetch_addr >= DEPTH_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      core_hold <= 1'b1;
      len_q     <= '0;
      word_cnt  <= '0;
      checksum  <= '0;
      load_err  <= 1'b0;
    end else begin
      if (word_valid) begin
        word_cnt <= word_cnt + (AW+1)'(1);
        checksum <= checksum + word;
      end
      unique case (state_q)
        IDLE, RUN: begin
          if (start_ok) begin
            if (load_len > DEPTH_LEN) begin
              load_err <= 1'b1;
            end else if (load_len == '0) begin
              state_q   <= RUN;
              core_hold <= 1'b0;
              word_cnt  <= '0;
              checksum  <= '0;
              load_err  <= 1'b0;
            end else begin
              state_q   <= LOAD;
              ready_q   <= 1'b1;
              core_hold <= 1'b1;
              len_q     <= load_len;
              word_cnt  <= '0;
              checksum  <= '0;
              load_err  <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (last_word) begin
            state_q <= FINISH;
            ready_q <= 1'b0;
          end
        end
        FINISH: begin
          // Final word is written during this cycle.
          state_q   <= RUN;
          core_hold <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: directed scenarios plus randomized loads.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  load_len;
  logic [31:0] fetch_addr;
  logic [31:0] imem_rd_addr;
  logic        core_hold;
  logic        fetch_fault;
  logic [8:0]  words_loaded;
  logic [31:0] checksum;
  logic        load_err;

  imem_boot_loader_if bif ();

  imem_boot_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_len     (load_len),
    .bus          (bif),
    .fetch_addr   (fetch_addr),
    .imem_rd_addr (imem_rd_addr),
    .core_hold    (core_hold),
    .fetch_fault  (fetch_fault),
    .words_loaded (words_loaded),
    .checksum     (checksum),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int last_we_cyc = -1;
  int fall_cyc = -1;
  logic hold_prev = 1'b1;

  int          exp_addr[$];
  logic [31:0] exp_data[$];

  // Reference model state
  logic        m_run;
  int          m_words;
  logic [31:0] m_sum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write must match the next expected (addr, data).
  always @(negedge clk) begin
    if (bif.mem_we === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", bif.mem_waddr, bif.mem_wdata);
      end else begin
        int          ea;
        logic [31:0] ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        chk("write_addr", 32'(bif.mem_waddr), 32'(ea));
        chk("write_data", bif.mem_wdata, ed);
      end
    end
    if (hold_prev && !core_hold) fall_cyc = cyc;
    hold_prev = core_hold;
  end

  // Little-endian word i of the stream is bytes 4i..4i+3.
  task automatic model_load(input int len, input logic [7:0] b[$]);
    m_sum   = 32'h0;
    m_words = len;
    for (int i = 0; i < len; i++) begin
      logic [31:0] w;
      w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
      exp_addr.push_back(i);
      exp_data.push_back(w);
      m_sum = m_sum + w;
    end
  endtask

  task automatic pulse_start(input int len);
    start    = 1'b1;
    load_len = 9'(len);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // mode 0: full rate, 1: one idle cycle before each byte, 2: random idles
  task automatic send_bytes(input logic [7:0] b[$], input int mode);
    foreach (b[i]) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        bif.s_valid = 1'b0;
        chk("ready_in_gap", 32'(bif.s_ready), 32'd1);
        @(posedge clk); #1;
      end
      begin
        logic acc;
        int   t;
        bif.s_valid = 1'b1;
        bif.s_data  = b[i];
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
          acc = bif.s_ready;
          @(posedge clk); #1;
          t++;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
      end
    end
    bif.s_valid = 1'b0;
  endtask

  task automatic wait_run_and_check(input string tag);
    int t;
    t = 0;
    while (core_hold !== 1'b0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_hold_fall"}, 32'(core_hold), 32'd0);
    @(negedge clk); #1;
    chk({tag, "_hold_after_last_write"}, 32'(fall_cyc), 32'(last_we_cyc + 1));
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(m_words));
    chk({tag, "_checksum"}, checksum, m_sum);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    m_run = 1'b1;
  endtask

  task automatic do_load(input string tag, input int len, input logic [7:0] b[$], input int mode);
    model_load(len, b);
    pulse_start(len);
    chk({tag, "_hold_rise"}, 32'(core_hold), 32'd1);
    send_bytes(b, mode);
    wait_run_and_check(tag);
  endtask

  task automatic do_reset();
    bif.s_valid = 1'b0;
    start       = 1'b0;
    reset       = 1'b1;
    #7;
    m_run   = 1'b0;
    m_words = 0;
    m_sum   = 32'h0;
    chk("rst_s_ready", 32'(bif.s_ready), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_fetch(input logic [31:0] a);
    fetch_addr = a;
    #1;
    chk("rd_addr", imem_rd_addr, m_run ? a : 32'd0);
    chk("fetch_fault", 32'(fetch_fault), 32'(m_run && (a >= 32'd256)));
  endtask

  initial begin
    logic [7:0] b[$];
    int we_base;

    reset       = 1'b1;
    start       = 1'b0;
    load_len    = '0;
    fetch_addr  = '0;
    bif.s_valid = 1'b0;
    bif.s_data  = '0;
    @(posedge clk); #1;
    do_reset();
    check_fetch(32'h200);

    // Two-word full-rate load
    b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load("tp1", 2, b, 0);
    chk("tp1_checksum_const", checksum, 32'h001000A6);

    // Single word, valid toggling every other cycle
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load("tp2", 1, b, 1);

    check_fetch(32'h05);
    check_fetch(32'h100);
    check_fetch(32'hFF);

    // Oversize length rejected in IDLE, then empty load opens RUN
    do_reset();
    pulse_start(257);
    chk("rej_load_err", 32'(load_err), 32'd1);
    chk("rej_s_ready", 32'(bif.s_ready), 32'd0);
    chk("rej_core_hold", 32'(core_hold), 32'd1);
    pulse_start(0);
    m_run = 1'b1;
    chk("len0_core_hold", 32'(core_hold), 32'd0);
    chk("len0_load_err", 32'(load_err), 32'd0);
    chk("len0_checksum", checksum, 32'd0);
    chk("len0_words", 32'(words_loaded), 32'd0);

    // Reset after 6 bytes of a 3-word load: only word 0 is written
    do_reset();
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    exp_addr.push_back(0);
    exp_data.push_back(32'h44332211);
    we_base = we_cnt;
    pulse_start(3);
    b = b[0:5];
    send_bytes(b, 0);
    @(negedge clk); #1;
    chk("midload_writes", 32'(we_cnt - we_base), 32'd1);
    do_reset();

    // Reload from RUN with a start pulse during LOAD that must be ignored
    pulse_start(0);
    m_run = 1'b1;
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_load(1, b);
    pulse_start(1);
    chk("reload_hold_rise", 32'(core_hold), 32'd1);
    send_bytes(b[0:1], 0);
    pulse_start(3);
    send_bytes(b[2:3], 0);
    wait_run_and_check("reload");

    // Randomized loads, rejects and fetches from RUN
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_start($urandom_range(257, 511));
        chk("rnd_rej_load_err", 32'(load_err), 32'd1);
        chk("rnd_rej_core_hold", 32'(core_hold), 32'd0);
      end else begin
        int len;
        len = $urandom_range(1, 6);
        b.delete();
        for (int k = 0; k < 4 * len; k++) b.push_back(8'($urandom));
        do_load("rnd", len, b, $urandom_range(0, 2));
      end
      for (int f = 0; f < 3; f++)
        check_fetch(($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_addr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
